axil_slave_adapter: RTL and testbench

- Parametrised AXI4-Lite slave front-end that converts bus transactions into single-cycle ASHI request pulses for an application register handler.
- Sits between the interconnect and the handler, as the next generation of the team's AXI4-Lite slave.
- Adds configurable address/data width, WSTRB pass-through, and strict AW+W pairing (no handler write until both are captured).
- Adds address-window decode with DECERR, a handler-timeout SLVERR, and registered read data held stable while RVALID is high.

---
 rtl/axil_slave_adapter.sv | 267 ++++++++++++++++++++++++++
 tb/tb_axil_slave_adapter.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_slave_adapter.sv
// AXI4-Lite slave front-end: turns bus transactions into single-cycle ASHI
// request pulses for an application register handler. Independent read and
// write FSMs; address-window decode (DECERR) and optional handler timeout
// (SLVERR). All outputs are registered or decoded from registered state, so
// every output is 0 after a reset edge.
//
// Write FSM
//   state  | meaning
//   W_IDLE | collecting AW and W (either order, or together)
//   W_EXEC | ASHI_WRITE pulse
//   W_WAIT | waiting for ASHI_WIDLE or timeout
//   W_RESP | BVALID held until BREADY
//
// Read FSM
//   state  | meaning
//   R_IDLE | ARREADY high, waiting for AR
//   R_EXEC | ASHI_READ pulse
//   R_WAIT | waiting for ASHI_RIDLE or timeout
//   R_RESP | RVALID held until RREADY
module axil_slave_adapter #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE      = '0,
  parameter logic [ADDR_WIDTH:0]   ADDR_SPAN      = '0,
  parameter int                    TIMEOUT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     AXI_AWADDR,
  input  logic                      AXI_AWVALID,
  output logic                      AXI_AWREADY,
  input  logic [2:0]                AXI_AWPROT,
  input  logic [DATA_WIDTH-1:0]     AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   AXI_WSTRB,
  input  logic                      AXI_WVALID,
  output logic                      AXI_WREADY,
  output logic [1:0]                AXI_BRESP,
  output logic                      AXI_BVALID,
  input  logic                      AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]     AXI_ARADDR,
  input  logic                      AXI_ARVALID,
  output logic                      AXI_ARREADY,
  input  logic [2:0]                AXI_ARPROT,
  output logic [DATA_WIDTH-1:0]     AXI_RDATA,
  output logic [1:0]                AXI_RRESP,
  output logic                      AXI_RVALID,
  input  logic                      AXI_RREADY,
  output logic [ADDR_WIDTH-1:0]     ASHI_WADDR,
  output logic [DATA_WIDTH-1:0]     ASHI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   ASHI_WSTRB,
  output logic                      ASHI_WRITE,
  input  logic                      ASHI_WIDLE,
  input  logic [1:0]                ASHI_WRESP,
  output logic [ADDR_WIDTH-1:0]     ASHI_RADDR,
  output logic                      ASHI_READ,
  input  logic                      ASHI_RIDLE,
  input  logic [DATA_WIDTH-1:0]     ASHI_RDATA,
  input  logic [1:0]                ASHI_RRESP
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_EXEC, R_WAIT, R_RESP} r_state_t;

  // Protection bits carry no meaning for this handler.
  logic unused_prot;
  assign unused_prot = ^{AXI_AWPROT, AXI_ARPROT};

  // Window test done one bit wider than the address so base+span never wraps.
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] a;
    logic [ADDR_WIDTH:0] base;
    logic [ADDR_WIDTH:0] off;
    a    = {1'b0, addr};
    base = {1'b0, ADDR_BASE};
    off  = a - base;
    if (ADDR_SPAN == '0) in_window = 1'b1;
    else                 in_window = (a >= base) && (off < ADDR_SPAN);
  endfunction

  // ---------------- write path ----------------
  w_state_t                w_state, w_next;
  logic                    aw_ready_q, w_ready_q;
  logic                    aw_done_q, aw_done_nx;
  logic                    wd_done_q, wd_done_nx;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       wstrb_q;
  logic [1:0]              bresp_q, bresp_nx;
  logic [CNT_W-1:0]        w_cnt_q, w_cnt_nx;
  logic                    aw_hs, w_hs;
  logic [ADDR_WIDTH-1:0]   waddr_eff;

  assign aw_hs     = AXI_AWVALID & aw_ready_q;
  assign w_hs      = AXI_WVALID & w_ready_q;
  // The address may be arriving in the same cycle the pair completes.
  assign waddr_eff = aw_hs ? AXI_AWADDR : waddr_q;

  // Write next-state: pair AW and W, decode, wait on handler, respond.
  always_comb begin
    w_next     = w_state;
    aw_done_nx = aw_done_q;
    wd_done_nx = wd_done_q;
    bresp_nx   = bresp_q;
    w_cnt_nx   = w_cnt_q;
    case (w_state)
      W_IDLE: begin
        if (aw_hs) aw_done_nx = 1'b1;
        if (w_hs)  wd_done_nx = 1'b1;
        if (aw_done_nx && wd_done_nx) begin
          aw_done_nx = 1'b0;
          wd_done_nx = 1'b0;
          if (in_window(waddr_eff)) begin
            w_next = W_EXEC;
          end else begin
            w_next   = W_RESP;
            bresp_nx = RESP_DECERR;
          end
        end
      end
      W_EXEC: w_next = W_WAIT;
      W_WAIT: begin
        if (ASHI_WIDLE) begin
          bresp_nx = ASHI_WRESP;
          w_next   = W_RESP;
        end else if (TIMEOUT_EN && (w_cnt_q == CNT_LIMIT)) begin
          bresp_nx = RESP_SLVERR;
          w_next   = W_RESP;
        end else if (TIMEOUT_EN) begin
          w_cnt_nx = w_cnt_q + 1'b1;
        end
      end
      W_RESP: begin
        if (AXI_BREADY) begin
          w_next   = W_IDLE;
          w_cnt_nx = '0;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write state, channel-ready flags and captured request fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state    <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      wd_done_q  <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= '0;
      w_cnt_q    <= '0;
    end else begin
      w_state    <= w_next;
      aw_ready_q <= (w_next == W_IDLE) && !aw_done_nx;
      w_ready_q  <= (w_next == W_IDLE) && !wd_done_nx;
      aw_done_q  <= aw_done_nx;
      wd_done_q  <= wd_done_nx;
      bresp_q    <= bresp_nx;
      w_cnt_q    <= w_cnt_nx;
      if (aw_hs) waddr_q <= AXI_AWADDR;
      if (w_hs) begin
        wdata_q <= AXI_WDATA;
        wstrb_q <= AXI_WSTRB;
      end
    end
  end

  assign AXI_AWREADY = aw_ready_q;
  assign AXI_WREADY  = w_ready_q;
  assign AXI_BVALID  = (w_state == W_RESP);
  assign AXI_BRESP   = bresp_q;
  assign ASHI_WRITE  = (w_state == W_EXEC);
  assign ASHI_WADDR  = waddr_q;
  assign ASHI_WDATA  = wdata_q;
  assign ASHI_WSTRB  = wstrb_q;

  // ---------------- read path ----------------
  r_state_t                r_state, r_next;
  logic                    ar_ready_q;
  logic [ADDR_WIDTH-1:0]   raddr_q;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_nx;
  logic [1:0]              rresp_q, rresp_nx;
  logic [CNT_W-1:0]        r_cnt_q, r_cnt_nx;
  logic                    ar_hs;

  assign ar_hs = AXI_ARVALID & ar_ready_q;

  // Read next-state: decode, wait on handler, hold data until accepted.
  always_comb begin
    r_next   = r_state;
    rdata_nx = rdata_q;
    rresp_nx = rresp_q;
    r_cnt_nx = r_cnt_q;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          if (in_window(AXI_ARADDR)) begin
            r_next = R_EXEC;
          end else begin
            r_next   = R_RESP;
            rresp_nx = RESP_DECERR;
            rdata_nx = '0;
          end
        end
      end
      R_EXEC: r_next = R_WAIT;
      R_WAIT: begin
        if (ASHI_RIDLE) begin
          rdata_nx = ASHI_RDATA;
          rresp_nx = ASHI_RRESP;
          r_next   = R_RESP;
        end else if (TIMEOUT_EN && (r_cnt_q == CNT_LIMIT)) begin
          rdata_nx = '0;
          rresp_nx = RESP_SLVERR;
          r_next   = R_RESP;
        end else if (TIMEOUT_EN) begin
          r_cnt_nx = r_cnt_q + 1'b1;
        end
      end
      R_RESP: begin
        if (AXI_RREADY) begin
          r_next   = R_IDLE;
          r_cnt_nx = '0;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read state, ARREADY and the registered address/data/response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= R_IDLE;
      ar_ready_q <= 1'b0;
      raddr_q    <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      r_cnt_q    <= '0;
    end else begin
      r_state    <= r_next;
      ar_ready_q <= (r_next == R_IDLE);
      rdata_q    <= rdata_nx;
      rresp_q    <= rresp_nx;
      r_cnt_q    <= r_cnt_nx;
      if (ar_hs) raddr_q <= AXI_ARADDR;
    end
  end

  assign AXI_ARREADY = ar_ready_q;
  assign AXI_RVALID  = (r_state == R_RESP);
  assign AXI_RDATA   = rdata_q;
  assign AXI_RRESP   = rresp_q;
  assign ASHI_READ   = (r_state == R_EXEC);
  assign ASHI_RADDR  = raddr_q;

endmodule

// File: tb/tb_axil_slave_adapter.sv
// Self-checking bench for axil_slave_adapter: 64-bit data, window
// 0x1000..0x10FF, handler timeout of 4 cycles.
module tb_axil_slave_adapter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] AXI_AWADDR = '0;
  logic          AXI_AWVALID = 1'b0;
  logic          AXI_AWREADY;
  logic [2:0]    AXI_AWPROT = 3'b010;
  logic [DW-1:0] AXI_WDATA = '0;
  logic [SW-1:0] AXI_WSTRB = '0;
  logic          AXI_WVALID = 1'b0;
  logic          AXI_WREADY;
  logic [1:0]    AXI_BRESP;
  logic          AXI_BVALID;
  logic          AXI_BREADY = 1'b0;
  logic [AW-1:0] AXI_ARADDR = '0;
  logic          AXI_ARVALID = 1'b0;
  logic          AXI_ARREADY;
  logic [2:0]    AXI_ARPROT = 3'b101;
  logic [DW-1:0] AXI_RDATA;
  logic [1:0]    AXI_RRESP;
  logic          AXI_RVALID;
  logic          AXI_RREADY = 1'b0;
  logic [AW-1:0] ASHI_WADDR;
  logic [DW-1:0] ASHI_WDATA;
  logic [SW-1:0] ASHI_WSTRB;
  logic          ASHI_WRITE;
  logic          ASHI_WIDLE = 1'b1;
  logic [1:0]    ASHI_WRESP = 2'b00;
  logic [AW-1:0] ASHI_RADDR;
  logic          ASHI_READ;
  logic          ASHI_RIDLE = 1'b1;
  logic [DW-1:0] ASHI_RDATA = '0;
  logic [1:0]    ASHI_RRESP = 2'b00;

  axil_slave_adapter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_BASE(32'h0000_1000),
    .ADDR_SPAN(33'h100), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY), .AXI_AWPROT(AXI_AWPROT),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY), .AXI_ARPROT(AXI_ARPROT),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY),
    .ASHI_WADDR(ASHI_WADDR), .ASHI_WDATA(ASHI_WDATA), .ASHI_WSTRB(ASHI_WSTRB), .ASHI_WRITE(ASHI_WRITE),
    .ASHI_WIDLE(ASHI_WIDLE), .ASHI_WRESP(ASHI_WRESP),
    .ASHI_RADDR(ASHI_RADDR), .ASHI_READ(ASHI_READ),
    .ASHI_RIDLE(ASHI_RIDLE), .ASHI_RDATA(ASHI_RDATA), .ASHI_RRESP(ASHI_RRESP)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  // Scoreboard queues: expectations pushed at stimulus time, observations
  // pushed by the monitors below.
  logic [AW+DW+SW-1:0] exp_w[$];
  logic [AW+DW+SW-1:0] obs_w[$];
  logic [1:0]          exp_b[$];
  logic [DW+1:0]       exp_r[$];
  logic [AW-1:0]       obs_r[$];
  int n_wpulse = 0;
  int n_rpulse = 0;
  int last_wpulse_cyc = 0;

  always @(negedge clk) begin
    if (ASHI_WRITE === 1'b1) begin
      n_wpulse++;
      last_wpulse_cyc = cyc;
      obs_w.push_back({ASHI_WADDR, ASHI_WDATA, ASHI_WSTRB});
    end
    if (ASHI_READ === 1'b1) begin
      n_rpulse++;
      obs_r.push_back(ASHI_RADDR);
    end
  end

  wire [210:0] all_out = {AXI_AWREADY, AXI_WREADY, AXI_BVALID, AXI_BRESP, AXI_ARREADY,
                          AXI_RVALID, AXI_RRESP, AXI_RDATA, ASHI_WADDR, ASHI_WDATA,
                          ASHI_WSTRB, ASHI_WRITE, ASHI_RADDR, ASHI_READ};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write_req(input string name);
    logic [AW+DW+SW-1:0] got;
    logic [AW+DW+SW-1:0] want;
    n_tests++;
    if (obs_w.size() == 0 || exp_w.size() == 0) begin
      n_fail++;
      $display("FAIL %s_req observed=%0d expected=%0d entries", name, obs_w.size(), exp_w.size());
    end else begin
      got = obs_w.pop_front();
      want = exp_w.pop_front();
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s_req got=%h want=%h", name, got, want);
      end
    end
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SW-1:0] strb, input logic [1:0] exp_resp,
                          input bit exp_pulse, input string name, output int lat);
    int p0;
    logic [1:0] eb;
    if (exp_pulse) exp_w.push_back({addr, data, strb});
    exp_b.push_back(exp_resp);
    p0 = n_wpulse;
    AXI_AWADDR = addr; AXI_WDATA = data; AXI_WSTRB = strb;
    AXI_AWVALID = 1'b1; AXI_WVALID = 1'b1; AXI_BREADY = 1'b1;
    n_tests++;
    if (AXI_AWREADY !== 1'b1 || AXI_WREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready got aw=%b w=%b want 1/1", name, AXI_AWREADY, AXI_WREADY);
    end
    step();
    AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0;
    lat = 0;
    while (AXI_BVALID !== 1'b1 && lat < 40) begin step(); lat++; end
    eb = exp_b.pop_front();
    n_tests++;
    if (AXI_BVALID !== 1'b1 || AXI_BRESP !== eb) begin
      n_fail++;
      $display("FAIL %s_bresp got valid=%b resp=%b want valid=1 resp=%b", name, AXI_BVALID, AXI_BRESP, eb);
    end
    step();
    n_tests++;
    if (AXI_BVALID !== 1'b0 || AXI_AWREADY !== 1'b1 || AXI_WREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_release got bvalid=%b awready=%b wready=%b want 0/1/1", name, AXI_BVALID, AXI_AWREADY, AXI_WREADY);
    end
    n_tests++;
    if (n_wpulse - p0 != (exp_pulse ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s_pulses got=%0d want=%0d", name, n_wpulse - p0, exp_pulse ? 1 : 0);
    end
    if (exp_pulse) check_write_req(name);
    else obs_w.delete();
    AXI_BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data,
                         input logic [1:0] exp_resp, input bit exp_pulse,
                         input string name, output int lat);
    int p0;
    logic [DW+1:0] want;
    logic [AW-1:0] ga;
    exp_r.push_back({exp_data, exp_resp});
    p0 = n_rpulse;
    AXI_ARADDR = addr; AXI_ARVALID = 1'b1; AXI_RREADY = 1'b1;
    n_tests++;
    if (AXI_ARREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_arready got=%b want=1", name, AXI_ARREADY);
    end
    step();
    AXI_ARVALID = 1'b0;
    lat = 0;
    while (AXI_RVALID !== 1'b1 && lat < 40) begin step(); lat++; end
    want = exp_r.pop_front();
    n_tests++;
    if (AXI_RVALID !== 1'b1 || {AXI_RDATA, AXI_RRESP} !== want) begin
      n_fail++;
      $display("FAIL %s_rdata got valid=%b data=%h resp=%b want data=%h resp=%b",
               name, AXI_RVALID, AXI_RDATA, AXI_RRESP, want[DW+1:2], want[1:0]);
    end
    step();
    n_tests++;
    if (AXI_RVALID !== 1'b0 || AXI_ARREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_release got rvalid=%b arready=%b want 0/1", name, AXI_RVALID, AXI_ARREADY);
    end
    n_tests++;
    if (n_rpulse - p0 != (exp_pulse ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s_pulses got=%0d want=%0d", name, n_rpulse - p0, exp_pulse ? 1 : 0);
    end
    if (exp_pulse && obs_r.size() > 0) begin
      ga = obs_r.pop_front();
      n_tests++;
      if (ga !== addr) begin
        n_fail++;
        $display("FAIL %s_raddr got=%h want=%h", name, ga, addr);
      end
    end
    obs_r.delete();
    AXI_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_tests++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=0", all_out);
    end
    reset = 1'b0;
    step();
    n_tests++;
    if (AXI_AWREADY !== 1'b1 || AXI_WREADY !== 1'b1 || AXI_ARREADY !== 1'b1 ||
        AXI_BVALID !== 1'b0 || AXI_RVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got aw=%b w=%b ar=%b bv=%b rv=%b want 1/1/1/0/0",
               AXI_AWREADY, AXI_WREADY, AXI_ARREADY, AXI_BVALID, AXI_RVALID);
    end
  endtask

  // AW at cycle 0, W at cycle 5: pulse at 6, BVALID at 8.
  task automatic test_write_split();
    int t0, p0;
    logic [1:0] eb;
    ASHI_WIDLE = 1'b1; ASHI_WRESP = 2'b00;
    p0 = n_wpulse; t0 = cyc;
    exp_w.push_back({32'h0000_1010, 64'h0123_4567_89AB_CDEF, 8'hFF});
    exp_b.push_back(2'b00);
    AXI_AWADDR = 32'h0000_1010; AXI_AWVALID = 1'b1; AXI_BREADY = 1'b1;
    step();
    AXI_AWVALID = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      n_tests++;
      if (AXI_WREADY !== 1'b1 || AXI_AWREADY !== 1'b0 || ASHI_WRITE !== 1'b0) begin
        n_fail++;
        $display("FAIL split_wait_c%0d got wready=%b awready=%b write=%b want 1/0/0", k, AXI_WREADY, AXI_AWREADY, ASHI_WRITE);
      end
      step();
    end
    AXI_WDATA = 64'h0123_4567_89AB_CDEF; AXI_WSTRB = 8'hFF; AXI_WVALID = 1'b1;
    step();
    AXI_WVALID = 1'b0;
    n_tests++;
    if (ASHI_WRITE !== 1'b1 || ASHI_WADDR !== 32'h0000_1010 || ASHI_WDATA !== 64'h0123_4567_89AB_CDEF) begin
      n_fail++;
      $display("FAIL split_c6 got write=%b addr=%h data=%h want 1/00001010/0123456789abcdef", ASHI_WRITE, ASHI_WADDR, ASHI_WDATA);
    end
    step();
    n_tests++;
    if (ASHI_WRITE !== 1'b0 || AXI_BVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL split_c7 got write=%b bvalid=%b want 0/0", ASHI_WRITE, AXI_BVALID);
    end
    step();
    eb = exp_b.pop_front();
    n_tests++;
    if (AXI_BVALID !== 1'b1 || AXI_BRESP !== eb) begin
      n_fail++;
      $display("FAIL split_c8 got bvalid=%b bresp=%b want 1/%b", AXI_BVALID, AXI_BRESP, eb);
    end
    step();
    n_tests++;
    if (n_wpulse - p0 != 1 || last_wpulse_cyc != t0 + 6) begin
      n_fail++;
      $display("FAIL split_pulse got count=%0d cycle=%0d want 1/%0d", n_wpulse - p0, last_wpulse_cyc - t0, 6);
    end
    check_write_req("split");
    AXI_BREADY = 1'b0;
  endtask

  // W first, AW three cycles later; handler returns EXOKAY.
  task automatic test_write_order();
    int t0, p0;
    logic [1:0] eb;
    ASHI_WIDLE = 1'b1; ASHI_WRESP = 2'b01;
    p0 = n_wpulse; t0 = cyc;
    exp_w.push_back({32'h0000_1048, 64'hFEED_0000_BEEF_1111, 8'hF0});
    exp_b.push_back(2'b01);
    AXI_WDATA = 64'hFEED_0000_BEEF_1111; AXI_WSTRB = 8'hF0; AXI_WVALID = 1'b1; AXI_BREADY = 1'b1;
    step();
    AXI_WVALID = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      n_tests++;
      if (AXI_WREADY !== 1'b0 || AXI_AWREADY !== 1'b1) begin
        n_fail++;
        $display("FAIL order_wait_c%0d got wready=%b awready=%b want 0/1", k, AXI_WREADY, AXI_AWREADY);
      end
      step();
    end
    AXI_AWADDR = 32'h0000_1048; AXI_AWVALID = 1'b1;
    step();
    AXI_AWVALID = 1'b0;
    step(); step();
    eb = exp_b.pop_front();
    n_tests++;
    if (AXI_BVALID !== 1'b1 || AXI_BRESP !== eb) begin
      n_fail++;
      $display("FAIL order_bresp got bvalid=%b bresp=%b want 1/%b", AXI_BVALID, AXI_BRESP, eb);
    end
    step();
    n_tests++;
    if (n_wpulse - p0 != 1 || last_wpulse_cyc != t0 + 4) begin
      n_fail++;
      $display("FAIL order_pulse got count=%0d cycle=%0d want 1/4", n_wpulse - p0, last_wpulse_cyc - t0);
    end
    check_write_req("order");
    AXI_BREADY = 1'b0;
    ASHI_WRESP = 2'b00;
  endtask

  task automatic test_window();
    int lat;
    ASHI_RIDLE = 1'b1; ASHI_RRESP = 2'b00; ASHI_RDATA = 64'h1111_2222_3333_4444;
    do_read(32'h0000_10FC, 64'h1111_2222_3333_4444, 2'b00, 1'b1, "win_last", lat);
    n_tests++;
    if (lat != 2) begin
      n_fail++;
      $display("FAIL win_latency got=%0d want=2 extra cycles", lat);
    end
    do_read(32'h0000_1100, 64'h0, 2'b11, 1'b0, "win_above", lat);
    do_read(32'h0000_0FFC, 64'h0, 2'b11, 1'b0, "win_below", lat);
    do_read(32'hFFFF_FFFC, 64'h0, 2'b11, 1'b0, "win_top", lat);
    do_write(32'h0000_1100, 64'h9999, 8'hFF, 2'b11, 1'b0, "win_wr_above", lat);
  endtask

  task automatic test_timeout();
    int lat, p0;
    logic [DW+1:0] want;
    ASHI_RIDLE = 1'b0; ASHI_RDATA = 64'h5555_5555_5555_5555; ASHI_RRESP = 2'b00;
    p0 = n_rpulse;
    exp_r.push_back({64'h0, 2'b10});
    AXI_ARADDR = 32'h0000_1008; AXI_ARVALID = 1'b1; AXI_RREADY = 1'b0;
    step();
    AXI_ARVALID = 1'b0;
    lat = 0;
    while (AXI_RVALID !== 1'b1 && lat < 30) begin step(); lat++; end
    n_tests++;
    if (AXI_RVALID !== 1'b1 || lat < 5 || lat > 7) begin
      n_fail++;
      $display("FAIL timeout_rise got rvalid=%b after=%0d want 1 within 5..7", AXI_RVALID, lat);
    end
    // Handler finishes late while the response is stalled.
    ASHI_RIDLE = 1'b1; ASHI_RDATA = 64'h0000_0000_DEAD_BEEF;
    want = exp_r.pop_front();
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (AXI_RVALID !== 1'b1 || {AXI_RDATA, AXI_RRESP} !== want) begin
        n_fail++;
        $display("FAIL timeout_hold%0d got valid=%b data=%h resp=%b want 1/%h/%b", k, AXI_RVALID, AXI_RDATA, AXI_RRESP, want[DW+1:2], want[1:0]);
      end
      step();
    end
    AXI_RREADY = 1'b1;
    step();
    AXI_RREADY = 1'b0;
    n_tests++;
    if (AXI_RVALID !== 1'b0 || n_rpulse - p0 != 1) begin
      n_fail++;
      $display("FAIL timeout_done got rvalid=%b pulses=%0d want 0/1", AXI_RVALID, n_rpulse - p0);
    end
    obs_r.delete();
    do_read(32'h0000_1008, 64'h0000_0000_DEAD_BEEF, 2'b00, 1'b1, "after_timeout", lat);
    ASHI_WIDLE = 1'b0;
    do_write(32'h0000_1018, 64'h7777, 8'h03, 2'b10, 1'b1, "wr_timeout", lat);
    ASHI_WIDLE = 1'b1;
  endtask

  task automatic test_concurrent();
    int n;
    bit b_done, r_done, b_stall, r_stall;
    logic [1:0] b_prev, eb;
    logic [DW+1:0] r_prev, er;
    for (int rnd = 0; rnd < 3; rnd++) begin
      ASHI_WIDLE = 1'b1; ASHI_RIDLE = 1'b1;
      ASHI_WRESP = 2'(rnd); ASHI_RRESP = 2'(2 - rnd);
      ASHI_RDATA = 64'hCAFE_F00D_0000_0000 | 64'(rnd);
      exp_b.push_back(2'(rnd));
      exp_r.push_back({64'hCAFE_F00D_0000_0000 | 64'(rnd), 2'(2 - rnd)});
      exp_w.push_back({32'h0000_1080 + 32'(rnd * 8), 64'hA0A0_0000_0000_0000 | 64'(rnd), 8'h5A});
      AXI_AWADDR = 32'h0000_1080 + 32'(rnd * 8); AXI_WDATA = 64'hA0A0_0000_0000_0000 | 64'(rnd);
      AXI_WSTRB = 8'h5A; AXI_ARADDR = 32'h0000_10C0;
      AXI_AWVALID = 1'b1; AXI_WVALID = 1'b1; AXI_ARVALID = 1'b1;
      step();
      AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0; AXI_ARVALID = 1'b0;
      b_done = 0; r_done = 0; b_stall = 0; r_stall = 0; n = 0;
      b_prev = '0; r_prev = '0;
      while (!(b_done && r_done) && n < 100) begin
        if (b_stall) begin
          n_tests++;
          if (AXI_BVALID !== 1'b1 || AXI_BRESP !== b_prev) begin
            n_fail++;
            $display("FAIL conc_bhold got valid=%b resp=%b want 1/%b", AXI_BVALID, AXI_BRESP, b_prev);
          end
        end
        if (r_stall) begin
          n_tests++;
          if (AXI_RVALID !== 1'b1 || {AXI_RDATA, AXI_RRESP} !== r_prev) begin
            n_fail++;
            $display("FAIL conc_rhold got valid=%b data=%h resp=%b want 1/%h/%b", AXI_RVALID, AXI_RDATA, AXI_RRESP, r_prev[DW+1:2], r_prev[1:0]);
          end
        end
        AXI_BREADY = 1'($urandom_range(1, 0));
        AXI_RREADY = 1'($urandom_range(1, 0));
        b_stall = (AXI_BVALID === 1'b1) && !AXI_BREADY && !b_done;
        r_stall = (AXI_RVALID === 1'b1) && !AXI_RREADY && !r_done;
        b_prev = AXI_BRESP;
        r_prev = {AXI_RDATA, AXI_RRESP};
        if (AXI_BVALID === 1'b1 && AXI_BREADY && !b_done) begin
          eb = exp_b.pop_front();
          n_tests++;
          if (AXI_BRESP !== eb) begin
            n_fail++;
            $display("FAIL conc_bresp%0d got=%b want=%b", rnd, AXI_BRESP, eb);
          end
          b_done = 1;
        end
        if (AXI_RVALID === 1'b1 && AXI_RREADY && !r_done) begin
          er = exp_r.pop_front();
          n_tests++;
          if ({AXI_RDATA, AXI_RRESP} !== er) begin
            n_fail++;
            $display("FAIL conc_rdata%0d got=%h/%b want=%h/%b", rnd, AXI_RDATA, AXI_RRESP, er[DW+1:2], er[1:0]);
          end
          r_done = 1;
        end
        step();
        n++;
      end
      AXI_BREADY = 1'b0; AXI_RREADY = 1'b0;
      n_tests++;
      if (!(b_done && r_done)) begin
        n_fail++;
        $display("FAIL conc_complete%0d got b=%0b r=%0b want 1/1", rnd, b_done, r_done);
        exp_b.delete(); exp_r.delete();
      end
      check_write_req("conc");
      obs_r.delete();
      step();
    end
    ASHI_WRESP = 2'b00; ASHI_RRESP = 2'b00;
  endtask

  task automatic test_reset_mid();
    int lat;
    ASHI_WIDLE = 1'b0;
    AXI_AWADDR = 32'h0000_1030; AXI_WDATA = 64'h1234_5678_9ABC_DEF0; AXI_WSTRB = 8'h3C;
    AXI_AWVALID = 1'b1; AXI_WVALID = 1'b1; AXI_BREADY = 1'b1;
    step();
    AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0;
    step();
    n_tests++;
    if (ASHI_WADDR !== 32'h0000_1030 || AXI_BVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_pre got waddr=%h bvalid=%b want 00001030/0", ASHI_WADDR, AXI_BVALID);
    end
    reset = 1'b1;
    step();
    n_tests++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got=%h want=0", all_out);
    end
    step();
    reset = 1'b0;
    step();
    n_tests++;
    if (AXI_AWREADY !== 1'b1 || AXI_WREADY !== 1'b1 || AXI_ARREADY !== 1'b1 || AXI_BVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_release got aw=%b w=%b ar=%b bv=%b want 1/1/1/0", AXI_AWREADY, AXI_WREADY, AXI_ARREADY, AXI_BVALID);
    end
    obs_w.delete(); exp_w.delete(); exp_b.delete();
    ASHI_WIDLE = 1'b1;
    do_write(32'h0000_1040, 64'h0BAD_F00D_0000_0042, 8'hFF, 2'b00, 1'b1, "mid_fresh", lat);
  endtask

  task automatic test_wide_strobe();
    int lat;
    ASHI_WIDLE = 1'b1; ASHI_WRESP = 2'b00;
    do_write(32'h0000_1020, 64'hA5A5_5A5A_F00D_CAFE, 8'h0F, 2'b00, 1'b1, "wide", lat);
    n_tests++;
    if (lat != 2) begin
      n_fail++;
      $display("FAIL wide_latency got=%0d want=2 extra cycles", lat);
    end
  endtask

  initial begin
    test_reset();
    test_write_split();
    test_write_order();
    test_window();
    test_timeout();
    test_concurrent();
    test_reset_mid();
    test_wide_strobe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
